// File: rtl/aec_pkg.sv
// Shared constants, FSM state encoding and the hex-digit renderer for the result formatter.
package aec_pkg;

    localparam int unsigned RES_W = 7;
    localparam int unsigned CHR_W = 8;

    localparam logic [CHR_W-1:0] ASC_0    = 8'd48;
    localparam logic [CHR_W-1:0] ASC_A_LC = 8'd97;
    localparam logic [CHR_W-1:0] ASC_EQ   = 8'd61;
    localparam logic [CHR_W-1:0] ASC_LF   = 8'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_TERM = 2'd3
    } fmt_state_t;

    // Lowercase ASCII hex digit for a 4-bit nibble.
    function automatic logic [CHR_W-1:0] hex(input logic [3:0] n);
        if (n < 4'd10)
            return ASC_0 + CHR_W'(n);
        else
            return ASC_A_LC - 8'd10 + CHR_W'(n);
    endfunction

endpackage

// File: rtl/aec_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO lands only when a pop happens on the same edge.
module aec_sync_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/aec_result_fmt.sv
// Buffers calculator results and streams each one out as lowercase hex digits plus a terminator byte.
module aec_result_fmt
    import aec_pkg::*;
#(
    parameter int unsigned  DEPTH       = 4,
    parameter logic [7:0]   TERM_CHAR   = 8'h0A,
    parameter bit           SUPPRESS_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res_data,
    output logic [CHR_W-1:0] char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fmt_state_t       state;
    fmt_state_t       state_d;
    logic [RES_W-1:0] h;
    logic [RES_W-1:0] h_d;
    logic [RES_W-1:0] head;
    logic             pop;
    logic             push_ok;
    logic             accept;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic [CHR_W-1:0] char_d;
    logic             valid_d;
    logic             busy_d;
    logic             ovf_d;

    aec_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (res_valid),
        .pop     (pop),
        .wr_data (res_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign accept  = char_valid && char_ready;
    assign push_ok = res_valid && (!full || pop);
    assign count_d = count + CW'(push_ok) - CW'(pop);

    // State, hold and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            h          <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_d;
            h          <= h_d;
            char_out   <= char_d;
            char_valid <= valid_d;
            busy       <= busy_d;
            overflow   <= ovf_d;
        end
    end

    // Next state: a pop from IDLE or after the terminator loads a new result with no bubble.
    always_comb begin
        state_d = state;
        h_d     = h;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: pop = !empty;
            ST_HI:   if (char_ready) state_d = ST_LO;
            ST_LO:   if (char_ready) state_d = ST_TERM;
            ST_TERM: begin
                if (char_ready) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            h_d     = head;
            state_d = (SUPPRESS_LZ && head[6:4] == 3'd0) ? ST_LO : ST_HI;
        end
    end

    // Output next values; the byte only changes on a handshake or a fresh pop.
    always_comb begin
        char_d  = char_out;
        valid_d = (state_d != ST_IDLE);
        busy_d  = (count_d != '0) || (state_d != ST_IDLE);
        ovf_d   = overflow || (res_valid && full && !pop);
        if (pop || accept) begin
            unique case (state_d)
                ST_HI:   char_d = hex({1'b0, h_d[6:4]});
                ST_LO:   char_d = hex(h_d[3:0]);
                ST_TERM: char_d = TERM_CHAR;
                default: char_d = char_out;
            endcase
        end
    end

endmodule
